// File: rtl/serout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serout_ctrl
// Brief    : Serial-output controller: holding register, shifter and
//            start/data/stop framing FSM advanced by a bit-rate tick.
// Revision : 1.0 - initial release
// ============================================================================
module serout_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 bitTick,
    input  logic                 wrStrobe,
    input  logic [DATA_BITS-1:0] wrData,
    input  logic                 forceBreak,
    input  logic                 clrOverrun,
    output logic                 serOut,
    output logic                 busy,
    output logic                 holdEmpty,
    output logic                 needData,
    output logic                 xmtDone,
    output logic                 overrun
);

    localparam int c_cntW = $clog2(DATA_BITS + 1);
    localparam logic [c_cntW-1:0] c_lastData = c_cntW'(DATA_BITS - 1);
    localparam logic [c_cntW-1:0] c_lastStop = c_cntW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [DATA_BITS-1:0]  r_hold;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_nextShift;
    logic [c_cntW-1:0]     r_bitCnt;
    logic [c_cntW-1:0]     w_nextBitCnt;
    logic                  r_holdEmpty;
    logic                  r_overrun;
    logic                  r_needData;
    logic                  r_serOut;
    logic                  w_load;
    logic                  w_bitVal;

    always_comb begin
        w_nextState  = r_state;
        w_nextShift  = r_shift;
        w_nextBitCnt = r_bitCnt;
        w_load       = 1'b0;
        w_bitVal     = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bitTick && !r_holdEmpty) begin
                    w_load      = 1'b1;
                    w_nextShift = r_hold;
                    w_nextState = S_START;
                end
            end
            S_START: begin
                w_bitVal = 1'b0;
                if (bitTick) begin
                    w_nextState  = S_DATA;
                    w_nextBitCnt = '0;
                end
            end
            S_DATA: begin
                w_bitVal = r_shift[0];
                if (bitTick) begin
                    w_nextShift = r_shift >> 1;
                    if (r_bitCnt == c_lastData) begin
                        w_nextState  = S_STOP;
                        w_nextBitCnt = '0;
                    end else begin
                        w_nextBitCnt = r_bitCnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bitTick) begin
                    if (r_bitCnt == c_lastStop) begin
                        w_nextBitCnt = '0;
                        // Pending data chains straight into the next start bit
                        if (!r_holdEmpty) begin
                            w_load      = 1'b1;
                            w_nextShift = r_hold;
                            w_nextState = S_START;
                        end else begin
                            w_nextState = S_IDLE;
                        end
                    end else begin
                        w_nextBitCnt = r_bitCnt + 1'b1;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_serOut <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_shift  <= w_nextShift;
            r_bitCnt <= w_nextBitCnt;
            r_serOut <= forceBreak ? 1'b0 : w_bitVal;
        end
    end

    // A write landing on a load edge refills the holder without overrun
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_hold      <= '0;
            r_holdEmpty <= 1'b1;
            r_overrun   <= 1'b0;
            r_needData  <= 1'b0;
        end else begin
            r_needData <= w_load;
            if (wrStrobe) begin
                r_hold      <= wrData;
                r_holdEmpty <= 1'b0;
            end else if (w_load) begin
                r_holdEmpty <= 1'b1;
            end
            if (wrStrobe && !r_holdEmpty && !w_load) begin
                r_overrun <= 1'b1;
            end else if (clrOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign serOut    = r_serOut;
    assign busy      = (r_state != S_IDLE);
    assign holdEmpty = r_holdEmpty;
    assign needData  = r_needData;
    assign xmtDone   = (r_state == S_IDLE) && r_holdEmpty;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serout_ctrl
// Brief    : Bench for serout_ctrl in 8N1 and 7N2 configurations against a
//            frame-queue model, plus literal per-tick serOut expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serout_ctrl;

    logic       clk        = 1'b0;
    logic       nReset     = 1'b0;
    logic       bitTick    = 1'b0;
    logic       wrStrobe   = 1'b0;
    logic [7:0] wrData     = 8'h00;
    logic       forceBreak = 1'b0;
    logic       clrOverrun = 1'b0;

    wire [1:0] dSer, dBusy, dHe, dNd, dXd, dOv;
    wire [1:0] mSer, mBusy, mHe, mNd, mXd, mOv;

    int nCmp    = 0;
    int nMis    = 0;
    int ndCount = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int D = (k == 0) ? 8 : 7;
        localparam int S = (k == 0) ? 1 : 2;

        serout_ctrl #(.DATA_BITS(D), .STOP_BITS(S)) u_dut (
            .clk        (clk),
            .nReset     (nReset),
            .bitTick    (bitTick),
            .wrStrobe   (wrStrobe),
            .wrData     (wrData[D-1:0]),
            .forceBreak (forceBreak),
            .clrOverrun (clrOverrun),
            .serOut     (dSer[k]),
            .busy       (dBusy[k]),
            .holdEmpty  (dHe[k]),
            .needData   (dNd[k]),
            .xmtDone    (dXd[k]),
            .overrun    (dOv[k])
        );

        // Model: a frame is a queue of remaining bit periods; each tick pops one
        logic [D-1:0] hv;
        logic         hf, ov, nd, ser, bz;
        bit           q[$];

        always @(posedge clk or negedge nReset) begin : p_model
            logic ld;
            logic [D-1:0] src;
            if (!nReset) begin
                hv = '0; hf = 1'b0; ov = 1'b0; nd = 1'b0; ser = 1'b1; bz = 1'b0;
                q.delete();
            end else begin
                ser = forceBreak ? 1'b0 : ((q.size() > 0) ? q[0] : 1'b1);
                ld  = 1'b0;
                if (bitTick) begin
                    if (q.size() > 0) void'(q.pop_front());
                    if (q.size() == 0 && hf) ld = 1'b1;
                end
                if (ld) begin
                    src = hv;
                    q.push_back(1'b0);
                    for (int i = 0; i < D; i++) q.push_back(src[i]);
                    for (int i = 0; i < S; i++) q.push_back(1'b1);
                end
                if (clrOverrun) ov = 1'b0;
                if (wrStrobe && hf && !ld) ov = 1'b1;
                if (wrStrobe) begin
                    hv = wrData[D-1:0];
                    hf = 1'b1;
                end else if (ld) begin
                    hf = 1'b0;
                end
                nd = ld;
                bz = (q.size() > 0);
            end
        end

        assign mSer[k]  = ser;
        assign mBusy[k] = bz;
        assign mHe[k]   = ~hf;
        assign mNd[k]   = nd;
        assign mXd[k]   = ~bz & ~hf;
        assign mOv[k]   = ov;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("serOut[%0d]", k),    dSer[k],  mSer[k]);
            chk($sformatf("busy[%0d]", k),      dBusy[k], mBusy[k]);
            chk($sformatf("holdEmpty[%0d]", k), dHe[k],   mHe[k]);
            chk($sformatf("needData[%0d]", k),  dNd[k],   mNd[k]);
            chk($sformatf("xmtDone[%0d]", k),   dXd[k],   mXd[k]);
            chk($sformatf("overrun[%0d]", k),   dOv[k],   mOv[k]);
        end
        if (dNd[0] === 1'b1) ndCount++;
    endtask

    task automatic checkReset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s serOut[%0d]", tag, k),    dSer[k],  1'b1);
            chk($sformatf("%s busy[%0d]", tag, k),      dBusy[k], 1'b0);
            chk($sformatf("%s holdEmpty[%0d]", tag, k), dHe[k],   1'b1);
            chk($sformatf("%s needData[%0d]", tag, k),  dNd[k],   1'b0);
            chk($sformatf("%s xmtDone[%0d]", tag, k),   dXd[k],   1'b1);
            chk($sformatf("%s overrun[%0d]", tag, k),   dOv[k],   1'b0);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #2;
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        #2 nReset = 1'b1;
    endtask

    task automatic doWrite(input logic [7:0] v, input logic clr = 1'b0);
        @(posedge clk); #2;
        wrStrobe = 1'b1; wrData = v; clrOverrun = clr;
        @(posedge clk); #2;
        wrStrobe = 1'b0; clrOverrun = 1'b0;
    endtask

    task automatic tickWait();
        repeat (12) @(posedge clk);
        #2 bitTick = 1'b1;
        @(posedge clk);
        #2 bitTick = 1'b0;
    endtask

    // expBits[i] is serOut during the bit period begun by tick i+1
    task automatic runTicks(input string tag, input int cfg, input int n,
                            input logic [31:0] expBits, input int wrAt = -1,
                            input logic [7:0] wrVal = 8'h00,
                            input int fbOn = -1, input int fbOff = -1);
        for (int i = 1; i <= n; i++) begin
            tickWait();
            if (i == fbOff) forceBreak = 1'b0;
            if (i == wrAt) doWrite(wrVal);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("%s tick%0d", tag, i), dSer[cfg], expBits[i-1]);
            if (i == fbOn) forceBreak = 1'b1;
        end
    endtask

    initial begin
        fork
            begin : p_compare
                forever begin
                    @(negedge clk);
                    compareAll();
                end
            end
            begin : p_stim
                int base;
                // 1: single 0x5A frame in 8N1
                repeat (3) @(posedge clk);
                #2 nReset = 1'b1;
                #1 checkReset("rst");
                base = ndCount;
                doWrite(8'h5A);
                #1;
                chk("t1 busyBeforeTick", dBusy[0], 1'b0);
                chk("t1 holdEmptyAfterWr", dHe[0], 1'b0);
                runTicks("t1", 0, 11, 32'h6B4);
                chk("t1 busyEnd", dBusy[0], 1'b0);
                chk("t1 xmtDoneEnd", dXd[0], 1'b1);
                chk("t1 needDataCount", 16'(ndCount - base), 16'd1);

                // 2: back-to-back frames
                base = ndCount;
                doWrite(8'h01);
                runTicks("t2", 0, 21, 32'h1C0202, 3, 8'h80);
                chk("t2 needDataCount", 16'(ndCount - base), 16'd2);
                chk("t2 overrun", dOv[0], 1'b0);
                chk("t2 xmtDoneEnd", dXd[0], 1'b1);

                // 3: overrun, last write wins, sticky flag and set-wins-clear
                doWrite(8'h11);
                doWrite(8'h22);
                #1 chk("t3 overrunSet", dOv[0], 1'b1);
                runTicks("t3", 0, 11, 32'h644);
                chk("t3 overrunSticky", dOv[0], 1'b1);
                @(posedge clk); #2 clrOverrun = 1'b1;
                @(posedge clk); #2 clrOverrun = 1'b0;
                #1 chk("t3 overrunCleared", dOv[0], 1'b0);
                doWrite(8'h33);
                doWrite(8'h44, 1'b1);
                #1 chk("t3 setWinsClear", dOv[0], 1'b1);
                doReset();

                // 4: forceBreak over several ticks of an 0xFF frame
                doWrite(8'hFF);
                runTicks("t4", 0, 11, 32'h78E, -1, 8'h00, 4, 8);
                chk("t4 busyEnd", dBusy[0], 1'b0);

                // 5: 7 data bits, 2 stop bits
                doReset();
                doWrite(8'h7F);
                runTicks("t5", 1, 10, 32'h3FE);
                chk("t5 busyInLastStop", dBusy[1], 1'b1);
                runTicks("t5end", 1, 1, 32'h1);
                chk("t5 busyEnd", dBusy[1], 1'b0);
                chk("t5 xmtDoneEnd", dXd[1], 1'b1);

                // 6: asynchronous reset mid-frame, then a fresh frame
                doReset();
                doWrite(8'h5A);
                runTicks("t6pre", 0, 4, 32'h4);
                chk("t6 busyPre", dBusy[0], 1'b1);
                #2 nReset = 1'b0;
                #1 checkReset("asyncRst");
                repeat (3) @(posedge clk);
                #2 nReset = 1'b1;
                base = ndCount;
                doWrite(8'h3C);
                runTicks("t6", 0, 11, 32'h678);
                chk("t6 needDataCount", 16'(ndCount - base), 16'd1);
                chk("t6 xmtDoneEnd", dXd[0], 1'b1);

                repeat (4) @(posedge clk);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
                $finish;
            end
        join
    end

endmodule
`default_nettype wire

// File: doc/serout_ctrl.md
Name: serout_ctrl

Overview:
Parametrised serial-output controller: the sequential successor to the fixed serial-out PLA. Provides a holding register, a shift register and a start/data/stop framing FSM, advanced by a bit-rate enable from the channel timers. Raises the serial-out "data needed" and "transmit done" interrupt sources. Drives the SIO data-out pin, with a force-break override.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..9.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
nReset  input  1  asynchronous active-low reset.
bitTick  input  1  one-clk-wide bit-period enable from the timer block.
wrStrobe  input  1  one-clk write strobe to the holding register (SEROUT write).
wrData  input  DATA_BITS  data written on wrStrobe.
forceBreak  input  1  when 1, serOut is held 0; the FSM keeps running.
clrOverrun  input  1  one-clk clear of the overrun flag.
serOut  output  1  registered serial data out; idle level is 1.
busy  output  1  1 while the FSM is not IDLE.
holdEmpty  output  1  1 when the holding register is empty.
needData  output  1  one-clk pulse when the holding register transfers to the shifter.
xmtDone  output  1  level: 1 when the FSM is IDLE and holdEmpty=1.
overrun  output  1  sticky: a write occurred while holdEmpty=0.

Behaviour:
- Reset (async, nReset=0): FSM=IDLE, serOut=1, busy=0, holdEmpty=1, needData=0, xmtDone=1, overrun=0; shifter, holding register and counters cleared. A reset mid-frame aborts the frame immediately; serOut returns to 1 asynchronously with reset.
- Write:
  - wrStrobe stores wrData in the holding register on that edge and sets holdEmpty=0.
  - If holdEmpty was already 0, the old data is overwritten and overrun is set to 1.
  - overrun clears only on clrOverrun. If clrOverrun and an overrunning write occur on the same edge, overrun=1 (set wins).
- FSM states and transitions (all transitions only on edges where bitTick=1):
  - IDLE: if holdEmpty=0, load the shifter from the holding register, set holdEmpty=1, pulse needData, go to START. A write never starts a frame without a bitTick.
  - START: entered with serOut=0 for one bit period. On the next tick go to DATA with bitCnt=0.
  - DATA: serOut = shifter[0]; shift right on each tick. After DATA_BITS ticks go to STOP.
  - STOP: serOut=1 for STOP_BITS ticks. On the last stop tick:
    - if holdEmpty=0, perform the IDLE load actions and go directly to START (back-to-back, no idle bit);
    - otherwise go to IDLE.
- serOut timing: serOut is registered and reflects the new state on the clk edge following the tick edge. A frame is exactly 1+DATA_BITS+STOP_BITS bit periods.
- Simultaneous wrStrobe and load on the same edge: the shifter takes the old holding contents; the new data stays in the holding register (holdEmpty=0, no overrun, needData still pulses).
- forceBreak=1: serOut=0 from the next edge. Framing, counters and interrupts continue unaffected. On release, serOut resumes the current FSM bit value.
- busy=1 in START/DATA/STOP. xmtDone drops on the same edge that leaves IDLE and rises on the edge entering IDLE with holdEmpty=1.
- bitTick asserted while IDLE and holdEmpty=1: no effect.
- Counter width: ceil(log2(DATA_BITS+1)) bits, no wrap beyond DATA_BITS.

Test Plan:
1. Reset then one write of 0x5A (DATA_BITS=8, STOP_BITS=1), bitTick every 16 clk -> needData pulses once at the first tick. serOut sequence per tick is 0,0,1,0,1,1,0,1,0,1. xmtDone=1 ten ticks later, busy=0.
2. Write 0x01, then write 0x80 during the data bits of the first frame -> frames are back-to-back with no idle bit between the stop bit and the second start bit. Two needData pulses; overrun=0.
3. Two writes (0x11, 0x22) before any tick -> overrun=1, and only 0x22 is transmitted. clrOverrun -> overrun=0.
4. forceBreak=1 during the 3rd data bit for 4 ticks -> serOut=0 throughout. On release, the FSM is in the correct bit position and the frame completes on time.
5. STOP_BITS=2, DATA_BITS=7, write 0x7F -> the frame lasts 10 ticks, with serOut=1 for the final 2.
6. nReset pulsed low mid-DATA -> all outputs at reset values immediately. The next write starts a fresh frame at the next tick.
